// File: rtl/servo_waypoint_sequencer_pkg.sv
// Shared types and limits for the servo waypoint sequencer: FSM encoding,
// servo range limits and the clamping helpers applied on table writes.
package servo_waypoint_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MOVE  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    localparam logic [7:0] MAX_ANGLE = 8'd180;
    localparam logic [6:0] MAX_SPEED = 7'd100;

    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        return (a > MAX_ANGLE) ? MAX_ANGLE : a;
    endfunction

    function automatic logic [6:0] clamp_speed(input logic [6:0] s);
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

endpackage

// File: rtl/servo_waypoint_sequencer_if.sv
// Bundle between the sequencer and its controller/servo: table write port,
// run control, servo command outputs, status and the FSM state for observation.
interface servo_waypoint_sequencer_if #(
    parameter int AW      = 3,
    parameter int DWELL_W = 16
);
    import servo_waypoint_sequencer_pkg::*;

    // start is a one-cycle request honoured only in IDLE (ignored while busy);
    // stop is a level that wins over everything; at_target is a level sampled
    // only in MOVE; there is no back-pressure on the table write strobe.
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [7:0]         wr_angle;
    logic [6:0]         wr_speed;
    logic [DWELL_W-1:0] wr_dwell;
    logic [AW:0]        num_wp;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic               at_target;

    logic [7:0]         angle;
    logic [6:0]         speed;
    logic               servo_en;
    logic [AW-1:0]      wp_idx;
    logic               busy;
    logic               done;
    logic               err;
    state_t             state;

    modport master (
        output wr_en, wr_addr, wr_angle, wr_speed, wr_dwell,
        output num_wp, loop_en, start, stop, at_target,
        input  angle, speed, servo_en, wp_idx, busy, done, err, state
    );

    modport slave (
        input  wr_en, wr_addr, wr_angle, wr_speed, wr_dwell,
        input  num_wp, loop_en, start, stop, at_target,
        output angle, speed, servo_en, wp_idx, busy, done, err, state
    );

endinterface

// File: rtl/servo_waypoint_sequencer_table.sv
// Waypoint storage: DEPTH entries of (angle, speed, dwell), clamped on a
// synchronous write and read combinationally. Contents are not reset.
module servo_waypoint_sequencer_table
    import servo_waypoint_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_angle,
    input  logic [6:0]         wr_speed,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW-1:0]      rd_addr,
    output logic [7:0]         rd_angle,
    output logic [6:0]         rd_speed,
    output logic [DWELL_W-1:0] rd_dwell
);

    logic [7:0]         angle_mem [DEPTH];
    logic [6:0]         speed_mem [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            angle_mem[wr_addr] <= clamp_angle(wr_angle);
            speed_mem[wr_addr] <= clamp_speed(wr_speed);
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    assign rd_angle = angle_mem[rd_addr];
    assign rd_speed = speed_mem[rd_addr];
    assign rd_dwell = dwell_mem[rd_addr];

endmodule

// File: rtl/servo_waypoint_sequencer.sv
// Steps the servo through the waypoint table: issue a target, wait for arrival,
// dwell, advance; runs once or loops, with stop, timeout and done reporting.
module servo_waypoint_sequencer
    import servo_waypoint_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DWELL_W = 16,
    parameter int TIMEOUT = 4096
) (
    input logic                       rotation_clk,
    input logic                       rst,
    servo_waypoint_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT);

    state_t             state;
    logic [7:0]         angle_q;
    logic [6:0]         speed_q;
    logic               servo_en_q;
    logic [AW-1:0]      wp_idx_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [AW:0]        num_wp_q;
    logic               loop_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [TW-1:0]      to_cnt;

    logic [7:0]         rd_angle;
    logic [6:0]         rd_speed;
    logic [DWELL_W-1:0] rd_dwell;
    logic [AW:0]        last_idx;
    logic               at_last;

    servo_waypoint_sequencer_table #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk      (rotation_clk),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_angle (bus.wr_angle),
        .wr_speed (bus.wr_speed),
        .wr_dwell (bus.wr_dwell),
        .rd_addr  (wp_idx_q),
        .rd_angle (rd_angle),
        .rd_speed (rd_speed),
        .rd_dwell (rd_dwell)
    );

    assign last_idx = num_wp_q - 1'b1;
    assign at_last  = ({1'b0, wp_idx_q} == last_idx);

    // The whole entry, dwell included, is captured at ISSUE so a table write
    // to the running entry only lands on its next ISSUE.
    always_ff @(posedge rotation_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            angle_q    <= '0;
            speed_q    <= '0;
            servo_en_q <= 1'b0;
            wp_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            num_wp_q   <= '0;
            loop_q     <= 1'b0;
            dwell_cnt  <= '0;
            to_cnt     <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && bus.num_wp != '0) begin
                            state    <= S_ISSUE;
                            busy_q   <= 1'b1;
                            wp_idx_q <= '0;
                            err_q    <= 1'b0;
                            num_wp_q <= (bus.num_wp > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_wp;
                            loop_q   <= bus.loop_en;
                        end
                    end
                    S_ISSUE: begin
                        angle_q    <= rd_angle;
                        speed_q    <= rd_speed;
                        dwell_cnt  <= rd_dwell;
                        servo_en_q <= 1'b1;
                        to_cnt     <= '0;
                        state      <= S_MOVE;
                    end
                    S_MOVE: begin
                        if (bus.at_target) begin
                            state <= S_DWELL;
                        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else if (!at_last) begin
                            wp_idx_q <= wp_idx_q + 1'b1;
                            state    <= S_ISSUE;
                        end else if (loop_q) begin
                            wp_idx_q <= '0;
                            state    <= S_ISSUE;
                        end else begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.angle    = angle_q;
    assign bus.speed    = speed_q;
    assign bus.servo_en = servo_en_q;
    assign bus.wp_idx   = wp_idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Directed bench for the waypoint sequencer: hand-timed runs against a lagging
// servo model, with an issued-waypoint queue checked as each target goes out.
module tb_servo_waypoint_sequencer;
    import servo_waypoint_sequencer_pkg::*;

    localparam int AW      = 3;
    localparam int DWELL_W = 16;
    localparam int TIMEOUT = 4096;
    localparam int W       = 16;

    logic rotation_clk = 1'b0;
    logic rst;

    servo_waypoint_sequencer_if #(.AW(AW), .DWELL_W(DWELL_W)) bus();

    servo_waypoint_sequencer #(
        .DEPTH   (8),
        .AW      (AW),
        .DWELL_W (DWELL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rotation_clk (rotation_clk),
        .rst          (rst),
        .bus          (bus)
    );

    // clock / reset
    always #5 rotation_clk = ~rotation_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done;
    int lag      = 0;
    logic servo_ok;
    state_t mon_prev = S_IDLE;
    logic [W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] wp_item(input logic [AW-1:0] idx, input logic [7:0] ang);
        return {5'd0, idx, ang};
    endfunction

    // servo model: arrival reported 4 cycles after the target is issued
    always @(posedge rotation_clk) begin
        #1;
        if (bus.state == S_ISSUE) lag = 4;
        else if (lag != 0) lag = lag - 1;
        bus.at_target = servo_ok && (lag == 0) && (bus.state != S_ISSUE);
    end

    // scoreboard: each issued target is compared as the DUT enters MOVE
    always @(posedge rotation_clk) begin
        #1;
        if (mon_prev == S_ISSUE) begin
            if (exp_q.size() == 0) check_val("issue_extra", 32'({5'd0, bus.wp_idx, bus.angle}), 32'hffff);
            else check_val("issue_seq", 32'({5'd0, bus.wp_idx, bus.angle}), 32'(exp_q.pop_front()));
        end
        mon_prev = bus.state;
    end

    // driver tasks
    task automatic tick();
        @(posedge rotation_clk);
        #1;
    endtask

    task automatic write_wp(input int addr, input int ang, input int spd, input int dw);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = AW'(addr);
        bus.wr_angle = 8'(ang);
        bus.wr_speed = 7'(spd);
        bus.wr_dwell = DWELL_W'(dw);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_angle"}, 32'(bus.angle), 0);
        check_val({tag, "_speed"}, 32'(bus.speed), 0);
        check_val({tag, "_servo_en"}, 32'(bus.servo_en), 0);
        check_val({tag, "_wp_idx"}, 32'(bus.wp_idx), 0);
        check_val({tag, "_busy"}, 32'(bus.busy), 0);
        check_val({tag, "_done"}, 32'(bus.done), 0);
        check_val({tag, "_err"}, 32'(bus.err), 0);
        check_val({tag, "_state"}, 32'(bus.state), 32'(S_IDLE));
    endtask

    initial begin
        rst = 1'b1;
        servo_ok = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_angle = '0; bus.wr_speed = '0; bus.wr_dwell = '0;
        bus.num_wp = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.at_target = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // single run over three entries
        write_wp(0, 90, 50, 2);
        write_wp(1, 0, 100, 0);
        write_wp(2, 180, 20, 5);
        bus.num_wp = 4'd3; bus.loop_en = 1'b0;
        exp_q.push_back(wp_item(0, 90));
        exp_q.push_back(wp_item(1, 0));
        exp_q.push_back(wp_item(2, 180));
        pulse_start();
        check_val("t1_issue_state", 32'(bus.state), 32'(S_ISSUE));
        check_val("t1_busy", 32'(bus.busy), 1);
        tick();
        check_val("t1_angle0", 32'(bus.angle), 90);
        check_val("t1_speed0", 32'(bus.speed), 50);
        check_val("t1_servo_en", 32'(bus.servo_en), 1);
        n_done = 0;
        repeat (23) begin
            tick();
            if (bus.done) n_done++;
        end
        check_val("t1_no_early_done", 32'(n_done), 0);
        tick();
        check_val("t1_done", 32'(bus.done), 1);
        check_val("t1_busy_drop", 32'(bus.busy), 0);
        check_val("t1_final_angle", 32'(bus.angle), 180);
        tick();
        check_val("t1_done_1cyc", 32'(bus.done), 0);
        check_val("t1_seq_drained", 32'(exp_q.size()), 0);

        // clamping of out-of-range writes
        write_wp(0, 200, 120, 0);
        bus.num_wp = 4'd1;
        exp_q.push_back(wp_item(0, 180));
        pulse_start();
        tick();
        check_val("t2_angle_clamp", 32'(bus.angle), 180);
        check_val("t2_speed_clamp", 32'(bus.speed), 100);
        wait_done("t2_done", 20);

        // looping over two entries, stopped mid-dwell
        write_wp(0, 30, 10, 1);
        write_wp(1, 150, 60, 3);
        bus.num_wp = 4'd2; bus.loop_en = 1'b1;
        exp_q.push_back(wp_item(0, 30));
        exp_q.push_back(wp_item(1, 150));
        exp_q.push_back(wp_item(0, 30));
        exp_q.push_back(wp_item(1, 150));
        exp_q.push_back(wp_item(0, 30));
        pulse_start();
        n_done = 0;
        repeat (37) begin
            tick();
            if (bus.done) n_done++;
        end
        check_val("t3_no_done", 32'(n_done), 0);
        check_val("t3_in_dwell", 32'(bus.state), 32'(S_DWELL));
        check_val("t3_wp_idx", 32'(bus.wp_idx), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_val("t3_stop_idle", 32'(bus.state), 32'(S_IDLE));
        check_val("t3_stop_busy", 32'(bus.busy), 0);
        check_val("t3_stop_angle", 32'(bus.angle), 30);
        check_val("t3_stop_en", 32'(bus.servo_en), 1);
        check_val("t3_stop_no_done", 32'(bus.done), 0);
        check_val("t3_seq_drained", 32'(exp_q.size()), 0);
        bus.loop_en = 1'b0;

        // move timeout
        write_wp(0, 60, 40, 0);
        bus.num_wp = 4'd1;
        servo_ok = 1'b0;
        exp_q.push_back(wp_item(0, 60));
        pulse_start();
        repeat (TIMEOUT) tick();
        check_val("t4_still_move", 32'(bus.state), 32'(S_MOVE));
        check_val("t4_no_err_yet", 32'(bus.err), 0);
        tick();
        check_val("t4_err", 32'(bus.err), 1);
        check_val("t4_idle", 32'(bus.state), 32'(S_IDLE));
        check_val("t4_busy", 32'(bus.busy), 0);
        check_val("t4_en_held", 32'(bus.servo_en), 1);
        check_val("t4_angle_held", 32'(bus.angle), 60);
        servo_ok = 1'b1;
        exp_q.push_back(wp_item(0, 60));
        pulse_start();
        check_val("t4_err_cleared", 32'(bus.err), 0);
        check_val("t4_restart", 32'(bus.state), 32'(S_ISSUE));
        wait_done("t4_done", 20);

        // rejected starts
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_val("t5_startstop_idle", 32'(bus.state), 32'(S_IDLE));
        check_val("t5_startstop_busy", 32'(bus.busy), 0);
        bus.num_wp = 4'd0;
        pulse_start();
        check_val("t5_zero_idle", 32'(bus.state), 32'(S_IDLE));
        check_val("t5_zero_busy", 32'(bus.busy), 0);
        bus.num_wp = 4'd1;

        // reset mid-move, then a zero-dwell entry
        exp_q.push_back(wp_item(0, 60));
        pulse_start();
        tick();
        tick();
        check_val("t6_in_move", 32'(bus.state), 32'(S_MOVE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("t6_rst");
        exp_q.push_back(wp_item(0, 60));
        pulse_start();
        repeat (5) tick();
        check_val("t6_dwell_one", 32'(bus.state), 32'(S_DWELL));
        tick();
        check_val("t6_dwell_exit", 32'(bus.state), 32'(S_IDLE));
        check_val("t6_done", 32'(bus.done), 1);
        check_val("t6_seq_drained", 32'(exp_q.size()), 0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
